// File: rtl/hc595_scan_driver.sv
// Serialises eight 7-segment bytes to a chained pair of 74HC595s, one multiplexed digit per latch.
// Define GHOST_BLANK_EN to shift and latch a blank word (16'hFF00) ahead of every data word.
module hc595_scan_driver #(
    parameter int CLK_DIV    = 4,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [63:0] seg_data,
    output logic        sclk,
    output logic        rclk,
    output logic        dio,
    output logic        busy,
    output logic [2:0]  digit_idx,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_HI,
        LATCH_LO
    } state_t;

    localparam logic [15:0] TICK_LAST  = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [15:0] BLANK_WORD = 16'hFF00;

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [3:0]  bit_q, bit_d;
    logic [63:0] snap_q, snap_d;
    logic [2:0]  digit_idx_q, digit_idx_d;
    logic        blank_q, blank_d;
    logic        sclk_q, sclk_d;
    logic        rclk_q, rclk_d;
    logic        dio_q, dio_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        tick;
    logic [15:0] word_d;

    always_comb begin
        tick         = (presc_q == TICK_LAST);
        state_d      = state_q;
        bit_d        = bit_q;
        snap_d       = snap_q;
        digit_idx_d  = digit_idx_q;
        blank_d      = blank_q;
        frame_done_d = 1'b0;
        presc_d      = (state_q == IDLE || state_q == LOAD || tick) ? 16'd0 : presc_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (digit_idx_q == 3'd0) begin
                    snap_d = seg_data;
                end
`ifdef GHOST_BLANK_EN
                blank_d = 1'b1;
`else
                blank_d = 1'b0;
`endif
                bit_d   = 4'd15;
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (tick) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    if (bit_q == 4'd0) begin
                        state_d = LATCH_HI;
                    end else begin
                        bit_d   = bit_q - 4'd1;
                        state_d = SHIFT_LO;
                    end
                end
            end
            LATCH_HI: begin
                if (tick) begin
                    state_d = LATCH_LO;
                end
            end
            LATCH_LO: begin
                if (tick) begin
                    // A latched blank word is followed straight away by the data word of the same digit.
                    if (blank_q) begin
                        blank_d = 1'b0;
                        bit_d   = 4'd15;
                        state_d = SHIFT_LO;
                    end else begin
                        frame_done_d = (digit_idx_q == LAST_DIGIT);
                        digit_idx_d  = frame_done_d ? 3'd0 : digit_idx_q + 3'd1;
                        state_d      = enable ? LOAD : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin values are derived from the next state so they change together with it.
        word_d = blank_d ? BLANK_WORD
                         : {snap_d[{digit_idx_d, 3'b000} +: 8], 8'd1 << digit_idx_d};
        sclk_d = (state_d == SHIFT_HI);
        rclk_d = (state_d == LATCH_HI);
        dio_d  = (state_d == SHIFT_LO || state_d == SHIFT_HI) ? word_d[bit_d] : 1'b0;
        busy_d = (state_d == SHIFT_LO || state_d == SHIFT_HI ||
                  state_d == LATCH_HI || state_d == LATCH_LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            presc_q      <= 16'd0;
            bit_q        <= 4'd0;
            snap_q       <= '1;
            digit_idx_q  <= 3'd0;
            blank_q      <= 1'b0;
            sclk_q       <= 1'b0;
            rclk_q       <= 1'b0;
            dio_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            bit_q        <= bit_d;
            snap_q       <= snap_d;
            digit_idx_q  <= digit_idx_d;
            blank_q      <= blank_d;
            sclk_q       <= sclk_d;
            rclk_q       <= rclk_d;
            dio_q        <= dio_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sclk       = sclk_q;
    assign rclk       = rclk_q;
    assign dio        = dio_q;
    assign busy       = busy_q;
    assign digit_idx  = digit_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hc595_scan_driver.sv
// Bench for hc595_scan_driver: a 74HC595 pin model captures every latched word, and directed
// tables/sequences check reset, word contents, frame timing, snapshot, enable and reset corners.
`timescale 1ns/1ps
module tb_hc595_scan_driver;

    localparam int CD = 2;
`ifdef GHOST_BLANK_EN
    localparam int WPD = 2;
`else
    localparam int WPD = 1;
`endif
    localparam int PER = 1 + 34 * WPD * CD;
    localparam logic [63:0] SEG_A = 64'hF9A4B0999282F8C0;
    localparam logic [63:0] SEG_B = 64'h7F7E7D7C7B7A7978;

    typedef struct {
        logic [63:0] seg;
        int          digit;
        logic [15:0] word;
    } vec_t;

    vec_t frame_tbl[8];
    vec_t snap_tbl[13];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] seg_data = 64'd0;
    logic        sclk, rclk, dio, busy, frame_done;
    logic [2:0]  digit_idx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [15:0] cap[$];
    int          rclk_cyc[$];
    int          fd_cyc[$];
    logic [15:0] shift_acc = 16'd0;
    int          sclk_edges = 0;
    int          bits_since_latch = 0;
    logic        sclk_prev = 1'b0;
    logic        rclk_prev = 1'b0;

    hc595_scan_driver #(.CLK_DIV(CD), .NUM_DIGITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .seg_data   (seg_data),
        .sclk       (sclk),
        .rclk       (rclk),
        .dio        (dio),
        .busy       (busy),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behaves like the shift register pair: shifts dio on sclk rise, copies the word out on rclk rise.
    always @(negedge clk) begin
        if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            shift_acc        <= {shift_acc[14:0], dio};
            sclk_edges       <= sclk_edges + 1;
            bits_since_latch <= bits_since_latch + 1;
        end
        if (rclk === 1'b1 && rclk_prev === 1'b0) begin
            cap.push_back(shift_acc);
            rclk_cyc.push_back(cyc);
            bits_since_latch <= 0;
        end
        if (frame_done === 1'b1) fd_cyc.push_back(cyc);
        sclk_prev <= sclk;
        rclk_prev <= rclk;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic [63:0] seg);
        rst      = r;
        enable   = en;
        seg_data = seg;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] data_at(input int i);
        if (WPD * i + WPD - 1 >= cap.size()) return 16'hxxxx;
        return cap[WPD * i + WPD - 1];
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n0, e0, f0, r0, t0, base, bad;

        frame_tbl[0] = '{SEG_A, 0, 16'hC001};
        frame_tbl[1] = '{SEG_A, 1, 16'hF802};
        frame_tbl[2] = '{SEG_A, 2, 16'h8204};
        frame_tbl[3] = '{SEG_A, 3, 16'h9208};
        frame_tbl[4] = '{SEG_A, 4, 16'h9910};
        frame_tbl[5] = '{SEG_A, 5, 16'hB020};
        frame_tbl[6] = '{SEG_A, 6, 16'hA440};
        frame_tbl[7] = '{SEG_A, 7, 16'hF980};

        snap_tbl[0]  = '{SEG_A, 3, 16'h9208};
        snap_tbl[1]  = '{SEG_A, 4, 16'h9910};
        snap_tbl[2]  = '{SEG_A, 5, 16'hB020};
        snap_tbl[3]  = '{SEG_A, 6, 16'hA440};
        snap_tbl[4]  = '{SEG_A, 7, 16'hF980};
        snap_tbl[5]  = '{SEG_B, 0, 16'h7801};
        snap_tbl[6]  = '{SEG_B, 1, 16'h7902};
        snap_tbl[7]  = '{SEG_B, 2, 16'h7A04};
        snap_tbl[8]  = '{SEG_B, 3, 16'h7B08};
        snap_tbl[9]  = '{SEG_B, 4, 16'h7C10};
        snap_tbl[10] = '{SEG_B, 5, 16'h7D20};
        snap_tbl[11] = '{SEG_B, 6, 16'h7E40};
        snap_tbl[12] = '{SEG_B, 7, 16'h7F80};

        // Reset values, then a long idle stretch with enable low.
        applyStimulus(1'b1, 1'b0, 64'd0);
        tick(3);
        checkOutput("rst_sclk", sclk, 0);
        checkOutput("rst_rclk", rclk, 0);
        checkOutput("rst_dio", dio, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_digit_idx", digit_idx, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        applyStimulus(1'b0, 1'b0, SEG_A);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({sclk, rclk, dio, busy, frame_done} !== 5'b0 || digit_idx !== 3'd0) bad++;
        end
        checkOutput("idle_quiet_cycles", bad, 0);

        // Two full frames with enable held; timing measured from the enable cycle.
        n0 = cap.size();
        e0 = sclk_edges;
        f0 = fd_cyc.size();
        r0 = rclk_cyc.size();
        t0 = cyc;
        applyStimulus(1'b0, 1'b1, frame_tbl[0].seg);
        while (cyc < t0 + 10) tick();
        checkOutput("busy_mid_shift", busy, 1);
        checkOutput("idx_first_digit", digit_idx, 0);
        while (cyc < t0 + PER) tick();
        checkOutput("idx_before_advance", digit_idx, 0);
        tick();
        checkOutput("idx_after_advance", digit_idx, 1);
        for (int i = 0; i < 3 * 8 * PER && fd_cyc.size() < f0 + 2; i++) tick();
        checkOutput("frame_done_count", fd_cyc.size() - f0, 2);
        checkOutput("frame_done_pulse_hi", frame_done, 1);
        checkOutput("idx_wrap", digit_idx, 0);
        checkOutput("first_latch_cycle", rclk_cyc[r0] - t0, 2 + 32 * CD);
        checkOutput("first_frame_done_cycle", fd_cyc[f0] - t0, 1 + 8 * PER);
        checkOutput("frame_period", fd_cyc[f0 + 1] - fd_cyc[f0], 8 * PER);
        checkOutput("sclk_edges_two_frames", sclk_edges - e0, 2 * 8 * 16 * WPD);
        checkOutput("words_two_frames", cap.size() - n0, 2 * 8 * WPD);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                checkOutput($sformatf("frame%0d_digit%0d", f, frame_tbl[k].digit),
                            data_at(n0 / WPD + 8 * f + frame_tbl[k].digit), frame_tbl[k].word);
            end
        end
`ifdef GHOST_BLANK_EN
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("blank_before_digit%0d", k), cap[n0 + 2 * k], 16'hFF00);
        end
`endif
        tick();
        checkOutput("frame_done_pulse_lo", frame_done, 0);

        // New seg_data while digit 3 shifts: old bytes until the next digit 0.
        for (int i = 0; i < 2 * 8 * PER && !(digit_idx == 3'd3 && busy === 1'b1); i++) tick();
        checkOutput("reach_digit3", digit_idx, 3);
        base = cap.size() / WPD;
        applyStimulus(1'b0, 1'b1, SEG_B);
        for (int i = 0; i < 3 * 8 * PER && cap.size() < (base + 13) * WPD; i++) tick();
        for (int j = 0; j < 13; j++) begin
            checkOutput($sformatf("snap_digit%0d_seg%0h", snap_tbl[j].digit, snap_tbl[j].seg[7:0]),
                        data_at(base + j), snap_tbl[j].word);
        end

        // Drop enable during digit 2: it still latches, then the scan parks at digit 3.
        for (int i = 0; i < 2 * 8 * PER && !(digit_idx == 3'd2 && busy === 1'b1); i++) tick();
        n0 = cap.size();
        applyStimulus(1'b0, 1'b0, SEG_B);
        for (int i = 0; i < 2 * PER && busy === 1'b1; i++) tick();
        checkOutput("drop_busy_low", busy, 0);
        checkOutput("drop_idx_held", digit_idx, 3);
        checkOutput("drop_words", cap.size() - n0, WPD);
        checkOutput("drop_last_word", cap[cap.size() - 1], 16'h7A04);
        e0 = sclk_edges;
        tick(30);
        checkOutput("idle_no_sclk", sclk_edges - e0, 0);
        checkOutput("idle_idx_hold", digit_idx, 3);

        n0 = cap.size();
        applyStimulus(1'b0, 1'b1, SEG_B);
        for (int i = 0; i < 2 * PER && cap.size() < n0 + WPD; i++) tick();
        checkOutput("resume_word", data_at(n0 / WPD), 16'h7B08);

        // Reset after the fifth shift edge of a word abandons it without a latch.
        for (int i = 0; i < 2 * PER && bits_since_latch != 5; i++) tick();
        checkOutput("reach_bit5", bits_since_latch, 5);
        n0 = cap.size();
        applyStimulus(1'b1, 1'b0, SEG_B);
        tick();
        checkOutput("midrst_sclk", sclk, 0);
        checkOutput("midrst_rclk", rclk, 0);
        checkOutput("midrst_dio", dio, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_digit_idx", digit_idx, 0);
        checkOutput("midrst_frame_done", frame_done, 0);
        applyStimulus(1'b0, 1'b0, SEG_B);
        tick(40);
        checkOutput("midrst_no_latch", cap.size() - n0, 0);

        n0 = cap.size();
        applyStimulus(1'b0, 1'b1, SEG_B);
        for (int i = 0; i < 2 * PER && cap.size() < n0 + WPD; i++) tick();
        checkOutput("restart_word", data_at(n0 / WPD), 16'h7801);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
